// File: rtl/price_bcd_converter.sv
// Price BCD converter: turns a 16-bit binary price into five BCD digits using
// a sequential double-dabble (shift-and-add-3) engine, then decodes the low
// four digits into active-low 7-segment codes for the HEX displays.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for START; outputs hold the last result
// SHIFT  | 16 add-3/shift iterations building the BCD scratch
// FINISH | publish scratch to BCD outputs, pulse DONE, back to IDLE
module price_bcd_converter #(
    parameter int BLANK_LEADING = 1
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        START,
    input  logic [15:0] PRICE_IN,
    output logic        BUSY,
    output logic        DONE,
    output logic [3:0]  BCD_0,
    output logic [3:0]  BCD_1,
    output logic [3:0]  BCD_2,
    output logic [3:0]  BCD_3,
    output logic [3:0]  BCD_4,
    output logic        OVERFLOW,
    output logic [6:0]  HEX0,
    output logic [6:0]  HEX1,
    output logic [6:0]  HEX2,
    output logic [6:0]  HEX3
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SHIFT  = 2'd1;
    localparam logic [1:0] FINISH = 2'd2;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    logic [1:0]  state;
    logic [15:0] shift_reg;
    logic [19:0] scratch;
    logic [19:0] scratch_adj;
    logic [4:0]  bit_cnt;

    // Add 3 to every scratch digit that is 5 or more, ahead of the shift.
    always_comb begin
        scratch_adj = scratch;
        for (int d = 0; d < 5; d++) begin
            if (scratch[d*4 +: 4] >= 4'd5)
                scratch_adj[d*4 +: 4] = scratch[d*4 +: 4] + 4'd3;
        end
    end

    // Conversion FSM, datapath registers and published result.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state     <= IDLE;
            shift_reg <= '0;
            scratch   <= '0;
            bit_cnt   <= '0;
            DONE      <= 1'b0;
            BCD_0     <= '0;
            BCD_1     <= '0;
            BCD_2     <= '0;
            BCD_3     <= '0;
            BCD_4     <= '0;
            OVERFLOW  <= 1'b0;
        end else begin
            DONE <= 1'b0;
            case (state)
                IDLE: begin
                    if (START) begin
                        shift_reg <= PRICE_IN;
                        scratch   <= '0;
                        bit_cnt   <= 5'd16;
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    scratch   <= {scratch_adj[18:0], shift_reg[15]};
                    shift_reg <= {shift_reg[14:0], 1'b0};
                    bit_cnt   <= bit_cnt - 5'd1;
                    // Counter hits zero on this edge: sixteenth shift done.
                    if (bit_cnt == 5'd1)
                        state <= FINISH;
                end
                FINISH: begin
                    BCD_0    <= scratch[3:0];
                    BCD_1    <= scratch[7:4];
                    BCD_2    <= scratch[11:8];
                    BCD_3    <= scratch[15:12];
                    BCD_4    <= scratch[19:16];
                    // Any nonzero ten-thousands digit means the value is >9999.
                    OVERFLOW <= (scratch[19:16] != 4'd0);
                    DONE     <= 1'b1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // BUSY tracks any non-IDLE state directly so it drops the edge FINISH ends.
    always_comb begin
        BUSY = (state != IDLE);
    end

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = SEG_BLANK;
        endcase
    endfunction

    logic show_all;
    logic blank3;
    logic blank2;
    logic blank1;

    // Leading-zero suppression; an overflowed value shows all four low digits.
    always_comb begin
        show_all = (BLANK_LEADING == 0) || OVERFLOW;
        blank3   = !show_all && (BCD_3 == 4'd0);
        blank2   = blank3 && (BCD_2 == 4'd0);
        blank1   = blank2 && (BCD_1 == 4'd0);
    end

    // Segment decode of the registered digits; HEX0 always shows a digit.
    always_comb begin
        HEX0 = seg7(BCD_0);
        HEX1 = blank1 ? SEG_BLANK : seg7(BCD_1);
        HEX2 = blank2 ? SEG_BLANK : seg7(BCD_2);
        HEX3 = blank3 ? SEG_BLANK : seg7(BCD_3);
    end

endmodule
